// File: rtl/conv_flatten.sv
// conv_flatten: layer-2 flatten stage.
// Reads the two pooled 32x32 maps (k0 on csel 011, k1 on csel 100) and writes
// them interleaved to the flatten region (csel 101): k0 -> even, k1 -> odd.
// Four cycles per pixel: RD0, RD1, WR0, WR1. All bus outputs are decoded from
// registered state only.
// Optional feature macro: FLAT_CHECKSUM_EN adds flat_sum, a 32-bit wrapping
// sum of every word written during the current/last run.
module conv_flatten #(
  parameter int unsigned N_PIX = 1024,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
`ifdef FLAT_CHECKSUM_EN
  ,
  output logic [31:0]   flat_sum
`endif
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd0  = 3'd1;
  localparam logic [2:0] StRd1  = 3'd2;
  localparam logic [2:0] StWr0  = 3'd3;
  localparam logic [2:0] StWr1  = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  localparam logic [2:0] SelIdle = 3'b000;
  localparam logic [2:0] SelK0   = 3'b011;
  localparam logic [2:0] SelK1   = 3'b100;
  localparam logic [2:0] SelFlat = 3'b101;

  localparam logic [AW-1:0] LastPix = AW'(N_PIX - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [DW-1:0] buf0_q, buf1_q;
  logic [AW-1:0] wr_base;

  // 2*pix computed at AW bits
  assign wr_base = {pix_q[AW-2:0], 1'b0};

  // Next-state logic and pixel counter update
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    case (state_q)
      StIdle: begin
        if (ready) begin
          state_d = StRd0;
          pix_d   = '0;
        end
      end
      StRd0:  state_d = StRd1;
      StRd1:  state_d = StWr0;
      StWr0:  state_d = StWr1;
      StWr1: begin
        if (pix_q == LastPix) begin
          state_d = StDone;
        end else begin
          pix_d   = pix_q + AW'(1);
          state_d = StRd0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and pixel counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  // Read data arrives one cycle after its address: k0 lands at the end of RD1,
  // k1 at the end of WR0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      if (state_q == StRd1) buf0_q <= cdata_rd;
      if (state_q == StWr0) buf1_q <= cdata_rd;
    end
  end

  // Bus outputs decoded from registered state
  always_comb begin
    busy     = (state_q != StIdle);
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = SelIdle;
    case (state_q)
      StRd0: begin
        crd      = 1'b1;
        csel     = SelK0;
        caddr_rd = pix_q;
      end
      StRd1: begin
        crd      = 1'b1;
        csel     = SelK1;
        caddr_rd = pix_q;
      end
      StWr0: begin
        cwr      = 1'b1;
        csel     = SelFlat;
        caddr_wr = wr_base;
        cdata_wr = buf0_q;
      end
      StWr1: begin
        cwr      = 1'b1;
        csel     = SelFlat;
        caddr_wr = wr_base + AW'(1);
        cdata_wr = buf1_q;
      end
      default: ;
    endcase
  end

`ifdef FLAT_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running sum of written words; cleared on start, held after DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == StIdle) && ready) begin
      sum_q <= '0;
    end else if (cwr) begin
      sum_q <= sum_q + 32'(cdata_wr);
    end
  end

  assign flat_sum = sum_q;
`endif

endmodule

// File: tb/tb_conv_flatten.sv
// Testbench for conv_flatten: synchronous one-cycle-latency memory model for
// the two pooled maps, cycle-by-cycle bus expectations derived from the
// pixel/phase schedule, and a write capture array for the flatten region.
`timescale 1ns/1ps
module tb_conv_flatten;

  localparam int N_PIX   = 1024;
  localparam int AW      = 12;
  localparam int DW      = 20;
  localparam int RUN_CYC = 4 * N_PIX + 1;

  logic          clk;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;
`ifdef FLAT_CHECKSUM_EN
  logic [31:0]   flat_sum;
`endif

  conv_flatten #(
    .N_PIX(N_PIX),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .crd     (crd),
    .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd),
    .cwr     (cwr),
    .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr),
    .csel    (csel)
`ifdef FLAT_CHECKSUM_EN
    ,
    .flat_sum(flat_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source maps and captured flatten region
  logic [DW-1:0] k0   [N_PIX];
  logic [DW-1:0] k1   [N_PIX];
  logic [DW-1:0] flat [2*N_PIX];

  int n_checks = 0;
  int n_bad    = 0;

  // Observations of the latest run
  int            cyc_err, first_bad, fall_cycle, restart_cycle;
  int            wr_cnt, seq_err, both_cnt;
  int            wr_cnt_s, seq_err_s, both_s;
  logic [AW-1:0] exp_wr_addr;

  // Memory: data for the address/csel of cycle t is presented during t+1
  always @(posedge clk) begin
    if (crd === 1'b1 && caddr_rd < AW'(N_PIX)) begin
      if (csel === 3'b011)      cdata_rd <= k0[caddr_rd[9:0]];
      else if (csel === 3'b100) cdata_rd <= k1[caddr_rd[9:0]];
      else                      cdata_rd <= 20'h5A5A5;
    end else begin
      cdata_rd <= 20'h3C3C3;
    end
  end

  // Write capture and bus-level bookkeeping
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (crd === 1'b1 && cwr === 1'b1) both_cnt++;
      if (cwr === 1'b1) begin
        if (caddr_wr !== exp_wr_addr) seq_err++;
        if (caddr_wr < AW'(2 * N_PIX)) flat[caddr_wr[10:0]] = cdata_wr;
        exp_wr_addr = exp_wr_addr + AW'(1);
        wr_cnt++;
      end
    end
  end

  task automatic fill_random;
    for (int i = 0; i < N_PIX; i++) begin
      k0[i] = DW'($urandom);
      k1[i] = DW'($urandom);
    end
  endtask

  // Starts one run and records per-cycle conformance against the 4-phase schedule
  task automatic do_run(input bit hold, input int pulse_at);
    bit e;
    int p, ph;
    for (int i = 0; i < 2 * N_PIX; i++) flat[i] = 'x;
    wr_cnt = 0; seq_err = 0; both_cnt = 0; exp_wr_addr = '0;
    cyc_err = 0; first_bad = -1; fall_cycle = -1; restart_cycle = -1;
    wr_cnt_s = -1; seq_err_s = -1; both_s = -1;
    @(negedge clk); ready = 1'b1;
    @(negedge clk); if (!hold) ready = 1'b0;
    for (int k = 0; k < RUN_CYC + 12; k++) begin
      if (!hold) begin
        if (k == pulse_at) ready = 1'b1;
        else if (k == pulse_at + 1) ready = 1'b0;
      end
      if (k < RUN_CYC) begin
        p  = k / 4;
        ph = k % 4;
        e  = 1'b0;
        if (busy !== 1'b1) e = 1'b1;
        if (k == RUN_CYC - 1) begin
          if (crd !== 1'b0 || cwr !== 1'b0 || csel !== 3'b000) e = 1'b1;
        end else begin
          case (ph)
            0: if (crd !== 1'b1 || cwr !== 1'b0 || csel !== 3'b011 ||
                   caddr_rd !== AW'(p)) e = 1'b1;
            1: if (crd !== 1'b1 || cwr !== 1'b0 || csel !== 3'b100 ||
                   caddr_rd !== AW'(p)) e = 1'b1;
            2: if (crd !== 1'b0 || cwr !== 1'b1 || csel !== 3'b101 ||
                   caddr_wr !== AW'(2 * p) || cdata_wr !== k0[p]) e = 1'b1;
            default: if (crd !== 1'b0 || cwr !== 1'b1 || csel !== 3'b101 ||
                   caddr_wr !== AW'(2 * p + 1) || cdata_wr !== k1[p]) e = 1'b1;
          endcase
        end
        if (e) begin
          cyc_err++;
          if (first_bad < 0) first_bad = k;
        end
      end
      if (k == RUN_CYC) begin
        wr_cnt_s = wr_cnt; seq_err_s = seq_err; both_s = both_cnt;
      end
      if (busy !== 1'b1 && fall_cycle < 0) fall_cycle = k;
      else if (busy === 1'b1 && fall_cycle >= 0 && restart_cycle < 0) restart_cycle = k;
      @(negedge clk);
    end
    ready = 1'b0;
    for (int k = 0; k < RUN_CYC + 8 && busy === 1'b1; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (crd !== 1'b0) begin n_bad++; $display("FAIL reset_crd got=%b want=0", crd); end
    n_checks++; if (cwr !== 1'b0) begin n_bad++; $display("FAIL reset_cwr got=%b want=0", cwr); end
    n_checks++; if (caddr_rd !== '0) begin n_bad++; $display("FAIL reset_caddr_rd got=%h want=0", caddr_rd); end
    n_checks++; if (caddr_wr !== '0) begin n_bad++; $display("FAIL reset_caddr_wr got=%h want=0", caddr_wr); end
    n_checks++; if (cdata_wr !== '0) begin n_bad++; $display("FAIL reset_cdata_wr got=%h want=0", cdata_wr); end
    n_checks++; if (csel !== 3'b000) begin n_bad++; $display("FAIL reset_csel got=%b want=000", csel); end
`ifdef FLAT_CHECKSUM_EN
    n_checks++; if (flat_sum !== 32'd0) begin n_bad++; $display("FAIL reset_flat_sum got=%h want=0", flat_sum); end
`endif
  endtask

  task automatic test_basic_interleave;
    int ferr;
    for (int i = 0; i < N_PIX; i++) begin
      k0[i] = DW'(i);
      k1[i] = 20'h80000 | DW'(i);
    end
    do_run(1'b0, -10);
    n_checks++; if (cyc_err !== 0) begin n_bad++;
      $display("FAIL basic_bus_schedule bad_cycles=%0d first=%0d want 0", cyc_err, first_bad); end
    n_checks++; if (fall_cycle !== RUN_CYC) begin n_bad++;
      $display("FAIL basic_busy_fall got=%0d want=%0d", fall_cycle, RUN_CYC); end
    n_checks++; if (wr_cnt_s !== 2 * N_PIX) begin n_bad++;
      $display("FAIL basic_write_count got=%0d want=%0d", wr_cnt_s, 2 * N_PIX); end
    n_checks++; if (seq_err_s !== 0) begin n_bad++;
      $display("FAIL basic_waddr_sequence errors=%0d want 0", seq_err_s); end
    n_checks++; if (both_s !== 0) begin n_bad++;
      $display("FAIL basic_crd_cwr_overlap cycles=%0d want 0", both_s); end
    ferr = 0;
    for (int i = 0; i < N_PIX; i++) begin
      if (flat[2*i] !== DW'(i) || flat[2*i+1] !== (20'h80000 | DW'(i))) ferr++;
    end
    n_checks++; if (ferr !== 0) begin n_bad++;
      $display("FAIL basic_flat_contents bad_pixels=%0d want 0", ferr); end
    n_checks++; if (restart_cycle !== -1) begin n_bad++;
      $display("FAIL basic_no_restart restarted_at=%0d want none", restart_cycle); end
  endtask

  task automatic test_boundary;
    int ferr;
    fill_random();
    k0[N_PIX-1] = 20'hFFFFF;
    k1[N_PIX-1] = 20'h00000;
    k0[0]       = 20'h7FFFF;
    do_run(1'b0, -10);
    n_checks++; if (flat[2046] !== 20'hFFFFF) begin n_bad++;
      $display("FAIL boundary_flat2046 got=%h want=fffff", flat[2046]); end
    n_checks++; if (flat[2047] !== 20'h00000) begin n_bad++;
      $display("FAIL boundary_flat2047 got=%h want=00000", flat[2047]); end
    n_checks++; if (flat[0] !== 20'h7FFFF) begin n_bad++;
      $display("FAIL boundary_flat0 got=%h want=7ffff", flat[0]); end
    ferr = 0;
    for (int i = 0; i < N_PIX; i++) if (flat[2*i] !== k0[i] || flat[2*i+1] !== k1[i]) ferr++;
    n_checks++; if (ferr !== 0 || cyc_err !== 0) begin n_bad++;
      $display("FAIL boundary_full bad_pixels=%0d bad_cycles=%0d want 0/0", ferr, cyc_err); end
  endtask

  task automatic test_ready_pulse_busy;
    int ferr;
    fill_random();
    do_run(1'b0, 137);
    n_checks++; if (restart_cycle !== -1) begin n_bad++;
      $display("FAIL pulse_ignored restarted_at=%0d want none", restart_cycle); end
    n_checks++; if (fall_cycle !== RUN_CYC || cyc_err !== 0) begin n_bad++;
      $display("FAIL pulse_run fall=%0d bad_cycles=%0d want %0d/0", fall_cycle, cyc_err, RUN_CYC); end
    ferr = 0;
    for (int i = 0; i < N_PIX; i++) if (flat[2*i] !== k0[i] || flat[2*i+1] !== k1[i]) ferr++;
    n_checks++; if (ferr !== 0) begin n_bad++;
      $display("FAIL pulse_flat_contents bad_pixels=%0d want 0", ferr); end
  endtask

  task automatic test_ready_held;
    fill_random();
    do_run(1'b1, -10);
    n_checks++; if (cyc_err !== 0 || fall_cycle !== RUN_CYC) begin n_bad++;
      $display("FAIL held_first_run bad_cycles=%0d fall=%0d want 0/%0d", cyc_err, fall_cycle, RUN_CYC); end
    n_checks++; if (restart_cycle !== RUN_CYC + 1) begin n_bad++;
      $display("FAIL held_restart got=%0d want=%0d", restart_cycle, RUN_CYC + 1); end
    n_checks++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL held_second_run_end busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int act;
    fill_random();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    repeat (22) @(negedge clk);
    n_checks++; if (cwr !== 1'b1 || caddr_wr !== AW'(10)) begin n_bad++;
      $display("FAIL midreset_at_wr0 cwr=%b caddr_wr=%0d want 1/10", cwr, caddr_wr); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    n_checks++; if (cwr !== 1'b0) begin n_bad++; $display("FAIL midreset_cwr got=%b want=0", cwr); end
    n_checks++; if (csel !== 3'b000) begin n_bad++; $display("FAIL midreset_csel got=%b want=000", csel); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || crd !== 1'b0 || cwr !== 1'b0) act++;
    end
    n_checks++; if (act !== 0) begin n_bad++;
      $display("FAIL midreset_quiet active_cycles=%0d want 0", act); end
  endtask

`ifdef FLAT_CHECKSUM_EN
  task automatic test_checksum;
    logic [31:0] model;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) fill_random();
      else begin
        for (int i = 0; i < N_PIX; i++) begin
          k0[i] = (r == 0) ? 20'h00001 : 20'hFFFFF;
          k1[i] = k0[i];
        end
      end
      model = '0;
      for (int i = 0; i < N_PIX; i++) model = model + 32'(k0[i]) + 32'(k1[i]);
      do_run(1'b0, -10);
      repeat (5) @(negedge clk);
      n_checks++; if (flat_sum !== model) begin n_bad++;
        $display("FAIL checksum_run%0d got=%h want=%h", r, flat_sum, model); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_basic_interleave();
    test_boundary();
    test_ready_pulse_busy();
    test_reset_mid_run();
    test_ready_held();
`ifdef FLAT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_flatten.md
Name: conv_flatten

Overview:
- Layer-2 flatten stage that runs directly after the conv/maxpool stage.
- Reads the two max-pooled 32x32 feature maps from the shared result memory: kernel 0 on csel=3'b011, kernel 1 on csel=3'b100.
- Writes them interleaved as one 2048-word vector on csel=3'b101: kernel0 to even addresses, kernel1 to odd addresses.
- Uses the same ready/busy handshake and the same cdata memory bus as the preceding stage.

Parameters:
- N_PIX, 1024, number of pooled pixels per kernel map.
- AW, 12, memory address width.
- DW, 20, data word width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ready  input  1  start request; sampled only in IDLE
- busy  output  1  high while flatten is in progress
- crd  output  1  memory read enable
- caddr_rd  output  AW  read address
- cdata_rd  input  DW  read data
- cwr  output  1  memory write enable
- caddr_wr  output  AW  write address
- cdata_wr  output  DW  write data
- csel  output  3  memory select: 3'b011 k0 pool, 3'b100 k1 pool, 3'b101 flatten, 3'b000 idle

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- All outputs are registered or decoded from registered state only. No combinational path from an input to any output.
- Reset values: busy=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, csel=3'b000, state=IDLE, pixel counter pix=0, buffers buf0=buf1=0.
- Memory read timing: cdata_rd is valid for the address/csel driven during cycle t, and is sampled at the rising edge ending cycle t+1.
- States:
  - IDLE: all enables 0, csel=3'b000. ready=1 at an edge -> RD0, busy=1 from the next cycle, pix=0.
  - RD0: crd=1, csel=3'b011, caddr_rd=pix. -> RD1.
  - RD1: crd=1, csel=3'b100, caddr_rd=pix. At the ending edge buf0<=cdata_rd (k0 word). -> WR0.
  - WR0: crd=0, cwr=1, csel=3'b101, caddr_wr=2*pix, cdata_wr=buf0. At the ending edge buf1<=cdata_rd (k1 word). -> WR1.
  - WR1: cwr=1, csel=3'b101, caddr_wr=2*pix+1, cdata_wr=buf1.
    - pix==N_PIX-1 -> DONE.
    - Otherwise pix<=pix+1 -> RD0.
  - DONE: one cycle, all enables 0, busy<=0. -> IDLE.
- Throughput: exactly 4 cycles per pixel. Total from first RD0 to DONE is 4*N_PIX+1 cycles (4097 at default).
- Data is passed unmodified. No sign handling or saturation; words are copied bit-exact.
- Address arithmetic: 2*pix+1 is computed at AW bits. Max value 2047, no wrap at the default.
- cwr and crd are never high in the same cycle.
- ready asserted while busy=1 is ignored. ready held high in IDLE after DONE starts a new run.
- Reset asserted mid-run aborts immediately to the reset values. No partial write is completed.

Optional Feature:
- Macro: FLAT_CHECKSUM_EN.
- When defined:
  - Adds output port flat_sum (32 bits, unsigned).
  - flat_sum is cleared on the IDLE->RD0 transition.
  - It accumulates the zero-extended cdata_wr on every cycle with cwr=1, wrapping modulo 2^32.
  - It holds its value after DONE until the next start. Reset value 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-run: assert reset during WR0 of pix=5 -> same cycle busy=0, cwr=0, csel=3'b000. After release, no activity until ready.
- Basic interleave:
  - Stimulus: k0[i]=i, k1[i]=20'h80000|i, pulse ready.
  - Required: flatten[2i]=i and flatten[2i+1]=20'h80000|i for all i<1024.
  - Required: busy falls exactly 4097 cycles after the first RD0, and exactly 2048 writes occur.
- Bus protocol check (per cycle):
  - crd&cwr never both 1.
  - csel is 011 / 100 / 101 in RD0 / RD1 / WR0-WR1 respectively.
  - caddr_wr sequence is 0,1,2,...,2047 with no gaps or repeats.
- Boundary data: k0[1023]=20'hFFFFF, k1[1023]=20'h00000, k0[0]=20'h7FFFF -> flatten[2046]=20'hFFFFF, flatten[2047]=0, flatten[0]=20'h7FFFF.
- Handshake:
  - ready held high throughout a run -> no restart before DONE; a second run starts the cycle after the return to IDLE.
  - ready pulse while busy -> ignored.
- FLAT_CHECKSUM_EN: all k0=k1=20'h00001 -> flat_sum=2048 after DONE. All words 20'hFFFFF -> flat_sum=2048*1048575 mod 2^32 = 32'h7FFFF800.
